// File: rtl/register_bank_32x32_pkg.sv
// Shared sizing, dump FSM state encoding and the byte-merge helper
// used by the register bank and its dump sequencer.
package register_bank_32x32_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BYTES_W    = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    // Byte-lane merge: lanes with be[i]=1 take new_v, the rest keep old_v.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]  old_v,
        input logic [DATA_W-1:0]  new_v,
        input logic [BYTES_W-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int unsigned i = 0; i < BYTES_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regbank_dump_fsm.sv
// Handshaked dump sequencer: walks register indices 0..31, one beat per
// accepted transfer, and pulses dump_done after the final beat.
module regbank_dump_fsm
    import register_bank_32x32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    input  logic [DATA_W-1:0]     capture_data,
    output logic [REG_ADDR_W-1:0] capture_addr,
    output logic                  dump_valid,
    output logic [REG_ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam logic [REG_ADDR_W-1:0] LAST_ADDR = REG_ADDR_W'(NUM_REGS - 1);

    dump_state_t state;

    // Index whose value is loaded into dump_data on the next capturing edge.
    always_comb begin
        capture_addr = '0;
        if (state == SEND) begin
            capture_addr = dump_addr + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dump_done <= 1'b0;
                    if (dump_start) begin
                        state      <= SEND;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                        dump_addr  <= '0;
                        dump_data  <= capture_data;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_addr == LAST_ADDR) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_addr <= dump_addr + 5'd1;
                            dump_data <= capture_data;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_bank_32x32.sv
// 32 x 32-bit register storage with a byte-enabled write port, parallel
// register outputs and a snapshot dump path forwarded from the write port.
module register_bank_32x32
    import register_bank_32x32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [BYTES_W-1:0]    ByteEn,
    output logic [DATA_W-1:0]     Reg0,
    output logic [DATA_W-1:0]     Reg1,
    output logic [DATA_W-1:0]     Reg2,
    output logic [DATA_W-1:0]     Reg3,
    output logic [DATA_W-1:0]     Reg4,
    output logic [DATA_W-1:0]     Reg5,
    output logic [DATA_W-1:0]     Reg6,
    output logic [DATA_W-1:0]     Reg7,
    output logic [DATA_W-1:0]     Reg8,
    output logic [DATA_W-1:0]     Reg9,
    output logic [DATA_W-1:0]     Reg10,
    output logic [DATA_W-1:0]     Reg11,
    output logic [DATA_W-1:0]     Reg12,
    output logic [DATA_W-1:0]     Reg13,
    output logic [DATA_W-1:0]     Reg14,
    output logic [DATA_W-1:0]     Reg15,
    output logic [DATA_W-1:0]     Reg16,
    output logic [DATA_W-1:0]     Reg17,
    output logic [DATA_W-1:0]     Reg18,
    output logic [DATA_W-1:0]     Reg19,
    output logic [DATA_W-1:0]     Reg20,
    output logic [DATA_W-1:0]     Reg21,
    output logic [DATA_W-1:0]     Reg22,
    output logic [DATA_W-1:0]     Reg23,
    output logic [DATA_W-1:0]     Reg24,
    output logic [DATA_W-1:0]     Reg25,
    output logic [DATA_W-1:0]     Reg26,
    output logic [DATA_W-1:0]     Reg27,
    output logic [DATA_W-1:0]     Reg28,
    output logic [DATA_W-1:0]     Reg29,
    output logic [DATA_W-1:0]     Reg30,
    output logic [DATA_W-1:0]     Reg31,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [REG_ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic                  write_hit;
    logic [REG_ADDR_W-1:0] capture_addr;
    logic [DATA_W-1:0]     capture_data;

    assign write_hit = RegWrite && (WriteRegister != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[WriteRegister] <= merge_bytes(regs[WriteRegister], WriteData, ByteEn);
        end
    end

    // Snapshot sees the post-write value when the write targets the captured index.
    always_comb begin
        capture_data = regs[capture_addr];
        if (capture_addr == '0) begin
            capture_data = '0;
        end else if (write_hit && (WriteRegister == capture_addr)) begin
            capture_data = merge_bytes(regs[capture_addr], WriteData, ByteEn);
        end
    end

    regbank_dump_fsm u_dump_fsm (
        .clk          (clk),
        .reset        (reset),
        .dump_start   (dump_start),
        .dump_ready   (dump_ready),
        .capture_data (capture_data),
        .capture_addr (capture_addr),
        .dump_valid   (dump_valid),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .dump_busy    (dump_busy),
        .dump_done    (dump_done)
    );

    assign Reg0  = '0;
    assign Reg1  = regs[1];
    assign Reg2  = regs[2];
    assign Reg3  = regs[3];
    assign Reg4  = regs[4];
    assign Reg5  = regs[5];
    assign Reg6  = regs[6];
    assign Reg7  = regs[7];
    assign Reg8  = regs[8];
    assign Reg9  = regs[9];
    assign Reg10 = regs[10];
    assign Reg11 = regs[11];
    assign Reg12 = regs[12];
    assign Reg13 = regs[13];
    assign Reg14 = regs[14];
    assign Reg15 = regs[15];
    assign Reg16 = regs[16];
    assign Reg17 = regs[17];
    assign Reg18 = regs[18];
    assign Reg19 = regs[19];
    assign Reg20 = regs[20];
    assign Reg21 = regs[21];
    assign Reg22 = regs[22];
    assign Reg23 = regs[23];
    assign Reg24 = regs[24];
    assign Reg25 = regs[25];
    assign Reg26 = regs[26];
    assign Reg27 = regs[27];
    assign Reg28 = regs[28];
    assign Reg29 = regs[29];
    assign Reg30 = regs[30];
    assign Reg31 = regs[31];

endmodule

// File: tb/tb_register_bank_32x32.sv
// Directed bench for register_bank_32x32: writes, byte enables, register 0,
// reset priority and the dump sequencer with and without back-pressure.
module tb_register_bank_32x32;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] r [32];
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int vectors;
    int miscompares;

    register_bank_32x32 dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ByteEn        (ByteEn),
        .Reg0  (r[0]),  .Reg1  (r[1]),  .Reg2  (r[2]),  .Reg3  (r[3]),
        .Reg4  (r[4]),  .Reg5  (r[5]),  .Reg6  (r[6]),  .Reg7  (r[7]),
        .Reg8  (r[8]),  .Reg9  (r[9]),  .Reg10 (r[10]), .Reg11 (r[11]),
        .Reg12 (r[12]), .Reg13 (r[13]), .Reg14 (r[14]), .Reg15 (r[15]),
        .Reg16 (r[16]), .Reg17 (r[17]), .Reg18 (r[18]), .Reg19 (r[19]),
        .Reg20 (r[20]), .Reg21 (r[21]), .Reg22 (r[22]), .Reg23 (r[23]),
        .Reg24 (r[24]), .Reg25 (r[25]), .Reg26 (r[26]), .Reg27 (r[27]),
        .Reg28 (r[28]), .Reg29 (r[29]), .Reg30 (r[30]), .Reg31 (r[31]),
        .dump_start    (dump_start),
        .dump_ready    (dump_ready),
        .dump_valid    (dump_valid),
        .dump_addr     (dump_addr),
        .dump_data     (dump_data),
        .dump_busy     (dump_busy),
        .dump_done     (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, {31'd0, dump_valid}, 32'd1);
        chk({tag, ".addr"},  {27'd0, dump_addr},  {27'd0, a});
        chk({tag, ".data"},  dump_data, d);
    endtask

    initial begin
        int beats;
        int dones;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ByteEn        = '0;
        dump_start    = 1'b0;
        dump_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) chk($sformatf("reset.reg%0d", i), r[i], 32'h0);
        chk("reset.valid", {31'd0, dump_valid}, 32'd0);
        chk("reset.busy",  {31'd0, dump_busy},  32'd0);
        chk("reset.done",  {31'd0, dump_done},  32'd0);
        chk("reset.addr",  {27'd0, dump_addr},  32'd0);
        chk("reset.data",  dump_data, 32'h0);

        // Full write, no write-through before the edge
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF; ByteEn = 4'hF;
        #1;
        chk("write.no_through", r[5], 32'h0);
        tick();
        chk("write.full", r[5], 32'hDEADBEEF);
        ByteEn = 4'b0010; WriteData = 32'h0000AA00;
        tick();
        chk("write.byte1", r[5], 32'hDEADAAEF);
        ByteEn = 4'b0000; WriteData = 32'h12345678;
        tick();
        chk("write.be0", r[5], 32'hDEADAAEF);
        ByteEn = 4'b1001; WriteData = 32'h11223344;
        tick();
        chk("write.be9", r[5], 32'h11ADAA44);

        // Register 0 ignores writes; reset beats a same-cycle write
        WriteRegister = 5'd0; WriteData = 32'hFFFFFFFF; ByteEn = 4'hF;
        tick();
        chk("reg0.write", r[0], 32'h0);
        reset = 1'b1; WriteRegister = 5'd3; WriteData = 32'hCAFEF00D;
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        tick();
        chk("reset_prio.reg3", r[3], 32'h0);
        chk("reset_prio.reg5", r[5], 32'h0);

        // Load reg i = 0x100 + i
        RegWrite = 1'b1; ByteEn = 4'hF;
        for (int i = 1; i < 32; i++) begin
            WriteRegister = 5'(i);
            WriteData     = 32'h100 + 32'(i);
            tick();
        end
        RegWrite = 1'b0;
        chk("load.reg31", r[31], 32'h11F);

        // Dump, no back-pressure
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk_beat($sformatf("dump1.b%0d", b), 5'(b), (b == 0) ? 32'h0 : 32'h100 + 32'(b));
            chk("dump1.busy", {31'd0, dump_busy}, 32'd1);
            chk("dump1.done_low", {31'd0, dump_done}, 32'd0);
            tick();
        end
        chk("dump1.done", {31'd0, dump_done}, 32'd1);
        chk("dump1.end_valid", {31'd0, dump_valid}, 32'd0);
        chk("dump1.end_busy", {31'd0, dump_busy}, 32'd0);
        tick();
        chk("dump1.done_once", {31'd0, dump_done}, 32'd0);

        // Dump with stalls on beat 7 and forwarding on beat 8
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 0; b < 7; b++) tick();
        chk_beat("stall.b7", 5'd7, 32'h107);
        dump_ready = 1'b0;
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h55;
        tick();
        RegWrite = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk_beat($sformatf("stall.hold%0d", s), 5'd7, 32'h107);
            if (s < 2) tick();
        end
        chk("stall.reg7", r[7], 32'h55);
        dump_ready = 1'b1;
        RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'h77;
        tick();
        RegWrite = 1'b0;
        chk_beat("fwd.b8", 5'd8, 32'h77);
        for (int b = 9; b < 32; b++) begin
            tick();
            chk_beat($sformatf("stall.b%0d", b), 5'(b), 32'h100 + 32'(b));
        end
        tick();
        chk("stall.done", {31'd0, dump_done}, 32'd1);
        tick();

        // Later dump shows the stalled write; reset at beat 12
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 0; b < 7; b++) tick();
        chk_beat("redump.b7", 5'd7, 32'h55);
        for (int b = 7; b < 12; b++) tick();
        chk_beat("redump.b12", 5'd12, 32'h10C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid.valid", {31'd0, dump_valid}, 32'd0);
        chk("rst_mid.busy",  {31'd0, dump_busy},  32'd0);
        chk("rst_mid.done",  {31'd0, dump_done},  32'd0);
        tick();
        chk("rst_mid.done2", {31'd0, dump_done},  32'd0);
        chk("rst_mid.valid2", {31'd0, dump_valid}, 32'd0);

        // Start during SEND is ignored: exactly 32 beats, one done pulse
        beats = 0;
        dones = 0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (dump_valid) beats++;
            if (dump_done) dones++;
            dump_start = (c == 3);
            tick();
        end
        dump_start = 1'b0;
        chk("ignore.beats", 32'(beats), 32'd32);
        chk("ignore.dones", 32'(dones), 32'd1);
        chk("ignore.idle", {31'd0, dump_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_bank_32x32.md
Name: register_bank_32x32

Overview:
Storage stage of the processor register file: 32 x 32-bit registers with one synchronous write port and byte enables. All 32 register contents are driven in parallel as Reg0..Reg31, directly into the 32-input read multiplexers. A handshaked dump sequencer streams every register out, one per beat, for the debug/trace path.

Parameters:
DATA_W, 32, register width in bits; fixed at 32, byte enables assume 4 bytes.
NUM_REGS, 32, number of registers; address width is log2(NUM_REGS) = 5.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
RegWrite  input  1  write enable for the write port.
WriteRegister  input  5  destination register index.
WriteData  input  32  write data.
ByteEn  input  4  per-byte write mask; bit i covers WriteData[8i+7:8i].
Reg0..Reg31  output  32 each  current register contents; feed the read multiplexers.
dump_start  input  1  one-cycle request to start a dump.
dump_ready  input  1  consumer accepts the current beat.
dump_valid  output  1  current beat is valid.
dump_addr  output  5  index of the register in the current beat.
dump_data  output  32  snapshot of that register.
dump_busy  output  1  high from dump start until the last beat is accepted.
dump_done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: synchronous, active-high, priority over all other inputs. All registers go to 0; FSM goes to IDLE. dump_valid, dump_busy and dump_done are 0; dump_addr and dump_data are 0.
- Write: on a clk edge with RegWrite=1 and WriteRegister!=0, each byte i with ByteEn[i]=1 takes the matching WriteData byte; other bytes hold their value.
  - The new value is visible on RegN the cycle after the edge (1-cycle latency); there is no combinational write-through.
  - RegWrite=1 with ByteEn=0 makes no change.
- Reg0: reads 32'h0 at all times; writes to index 0 are ignored.
- Reg0..Reg31 are direct register outputs with no logic after the flops.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_valid=0, dump_busy=0. On dump_start=1, go to SEND, set dump_addr=0, and capture dump_data from register 0.
  - SEND: dump_valid=1, dump_busy=1. dump_addr and dump_data stay stable while dump_ready=0.
  - SEND with dump_ready=1 and dump_addr<31: increment dump_addr and capture the next register.
  - SEND with dump_ready=1 and dump_addr=31: go to DONE.
  - DONE: dump_valid=0, dump_busy=0, dump_done=1 for exactly one cycle, then go to IDLE.
- Snapshot rule: dump_data captures the register's value after any write in the same cycle, i.e. it is forwarded from the write port. Writes to a register already captured do not change the beat being presented.
- A full dump with dump_ready held high takes 32 beats: the first beat appears one cycle after dump_start, and dump_done pulses one cycle after the last beat.
- dump_start while in SEND or DONE is ignored; it is not queued.
- Writes proceed normally during a dump; the dump never stalls the write port.
- Reset mid-dump: the FSM returns to IDLE the next cycle, with no dump_done pulse and dump_valid=0.

Decomposition:
- Shared package holds DATA_W, NUM_REGS, REG_ADDR_W=5, and the dump state encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2).
- One sub-module is natural: regbank_dump_fsm (state, dump_addr counter, handshake, done pulse).
- regbank_dump_fsm takes the forwarded capture value from the parent.
- Storage, byte-enable write logic and forwarding stay in the parent.

Test Plan:
- Reset check: reset=1 for 2 cycles, then release -> Reg0..Reg31 = 0, dump_valid = 0, dump_busy = 0.
- Full write: write 32'hDEADBEEF to reg 5 with ByteEn=4'hF, then ByteEn=4'b0010 with WriteData=32'h0000AA00 -> Reg5=32'hDEADBEEF, then 32'hDEADAAEF.
- Register 0: write 32'hFFFFFFFF to reg 0 -> Reg0 stays 0; same-cycle reset and RegWrite to reg 3 -> Reg3=0.
- Dump, no back-pressure: load reg i = 32'h100+i, pulse dump_start, hold dump_ready=1 -> beats addr 0..31 with data 0,32'h101..32'h11F on consecutive cycles; dump_done pulses once.
- Dump with stalls: hold dump_ready=0 for 3 cycles on beat addr=7 -> addr and data stable; write reg 7 = 32'h55 during the stall -> beat 7 unchanged; a later dump shows 32'h55. Write reg 8 = 32'h77 in the cycle beat 8 is captured -> beat 8 shows 32'h77.
- Reset and ignored start: assert reset at beat addr=12 -> next cycle dump_valid=0, dump_busy=0, no dump_done. Pulse dump_start during SEND -> ignored, and exactly 32 beats are produced.
